// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns stage: mixes COLS_PER_CYCLE columns per clock, holds result
// until accepted downstream; per-block bypass passes the state through for the final round.
module mix_columns_iter #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int unsigned NCALC    = 4 / COLS_PER_CYCLE;
    localparam int unsigned LAST_CNT = (NCALC - 1) * COLS_PER_CYCLE;
    localparam int unsigned COL_W    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] work_q, work_d;
    logic [2:0]   col_lo, col_hi;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // One column, row 0 in the most significant byte.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Next-state, counter and working-register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        col_lo  = {1'b0, cnt_q};
        col_hi  = col_lo + 3'(COLS_PER_CYCLE);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = state_in;
                    cnt_d   = '0;
                    state_d = bypass ? DONE : CALC;
                end
            end
            CALC: begin
                for (int c = 0; c < 4; c++) begin
                    if ((3'(c) >= col_lo) && (3'(c) < col_hi)) begin
                        work_d[(3 - c) * COL_W +: COL_W] = mix_col(work_q[(3 - c) * COL_W +: COL_W]);
                    end
                end
                cnt_d = cnt_q + 2'(COLS_PER_CYCLE);
                if (cnt_q == 2'(LAST_CNT)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; handshake/status outputs registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            out_valid <= (state_d == DONE);
            in_ready  <= (state_d == IDLE);
            busy      <= (state_d != IDLE);
        end
    end

    assign state_out = work_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Self-checking bench for mix_columns_iter: directed cases plus random blocks
// checked against a generic GF(2^8) matrix-multiply model.
module tb_mix_columns_iter;

    localparam int unsigned COLS  = 1;
    localparam int unsigned NCALC = 4 / COLS;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    int n_cmp;
    int n_err;

    mix_columns_iter #(.COLS_PER_CYCLE(COLS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .bypass    (bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    // Shift-and-add GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] aa;
        logic [7:0] p;
        aa = {1'b0, a};
        p  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa[7:0];
            aa = aa << 1;
            if (aa[8]) aa = aa ^ 9'h11b;
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] s);
        logic [7:0] m [4][4];
        logic [7:0] acc;
        logic [127:0] r;
        m = '{'{8'd2, 8'd3, 8'd1, 8'd1},
              '{8'd1, 8'd2, 8'd3, 8'd1},
              '{8'd1, 8'd1, 8'd2, 8'd3},
              '{8'd3, 8'd1, 8'd1, 8'd2}};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gmul(m[row][k], s[127 - (32 * c + 8 * k) -: 8]);
                end
                r[127 - (32 * c + 8 * row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one block at a negedge, then count cycles until out_valid (bounded).
    task automatic accept_wait(input logic [127:0] d, input logic byp, output int lat);
        @(negedge clk);
        state_in = d;
        bypass   = byp;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_out_valid", 128'(out_valid), 128'd0);
        chk("post_hs_in_ready", 128'(in_ready), 128'd1);
    endtask

    logic [127:0] fips_in, fips_out, known_in, known_out, byp_in, d, held, exp_q [$];
    logic [127:0] blk [3];
    int lat, cyc, busy_cnt, spurious, idx, seen;
    int out_cyc [$];
    logic [127:0] out_val [$];
    logic byp;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        state_in = '0;
        bypass = 1'b0;
        out_ready = 1'b0;
        fips_in   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        fips_out  = 128'h046681e5e0cb199a48f8d37a2806264c;
        known_in  = 128'hdb135345f20a225c01010101d4d4d4d5;
        known_out = 128'h8e4da1bc9fdc589d01010101d5d5d7d6;
        byp_in    = 128'h00112233445566778899aabbccddeeff;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_state_out", state_out, 128'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // FIPS-197 round 1 vector with latency
        accept_wait(fips_in, 1'b0, lat);
        chk("fips_state_out", state_out, fips_out);
        chk("fips_latency", 128'(lat), 128'(NCALC + 1));
        chk("fips_model", mix_ref(fips_in), fips_out);
        consume();

        // Known columns, checked per column
        accept_wait(known_in, 1'b0, lat);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("known_col%0d", c), 128'(state_out[127 - 32 * c -: 32]),
                128'(known_out[127 - 32 * c -: 32]));
        end
        consume();

        // Bypass: passes unchanged, busy high one cycle
        @(negedge clk);
        out_ready = 1'b1;
        state_in = byp_in;
        bypass = 1'b1;
        in_valid = 1'b1;
        busy_cnt = 0;
        seen = 0;
        held = '0;
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (busy) busy_cnt++;
            if (out_valid && seen == 0) begin
                seen = 1;
                held = state_out;
                lat = i;
            end
        end
        out_ready = 1'b0;
        bypass = 1'b0;
        chk("byp_state_out", held, byp_in);
        chk("byp_latency", 128'(lat), 128'd1);
        chk("byp_busy_cycles", 128'(busy_cnt), 128'd1);

        // Backpressure: hold 10 cycles while a new block is offered
        d = {$urandom, $urandom, $urandom, $urandom};
        accept_wait(d, 1'b0, lat);
        held = mix_ref(d);
        chk("bp_first", state_out, held);
        state_in = ~d;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("bp_stable%0d", i), state_out, held);
            chk($sformatf("bp_valid%0d", i), 128'(out_valid), 128'd1);
            chk($sformatf("bp_in_ready%0d", i), 128'(in_ready), 128'd0);
        end
        in_valid = 1'b0;
        consume();
        chk("bp_no_accept_busy", 128'(busy), 128'd0);

        // Reset asserted mid-CALC
        accept_wait(fips_in, 1'b0, lat);
        consume();
        @(negedge clk);
        state_in = fips_in;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        chk("midcalc_busy", 128'(busy), 128'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_state_out", state_out, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        spurious = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        out_ready = 1'b0;
        chk("postrst_spurious", 128'(spurious), 128'd0);

        // Back-to-back: in_valid held, out_ready high, three blocks
        for (int i = 0; i < 3; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b1;
        idx = 0;
        cyc = 0;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                out_cyc.push_back(cyc);
                out_val.push_back(state_out);
            end
            if (idx < 3) begin
                state_in = blk[idx];
                bypass = 1'b0;
                in_valid = 1'b1;
                if (in_ready) idx++;
            end else begin
                in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        chk("b2b_count", 128'(out_val.size()), 128'd3);
        for (int i = 0; i < 3 && i < out_val.size(); i++) begin
            chk($sformatf("b2b_val%0d", i), out_val[i], mix_ref(blk[i]));
            if (i > 0) chk($sformatf("b2b_gap%0d", i), 128'(out_cyc[i] - out_cyc[i - 1]), 128'(NCALC + 2));
        end

        // Random blocks with random bypass and random hold time
        for (int i = 0; i < 24; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            byp = ($urandom_range(0, 3) == 0);
            accept_wait(d, byp, lat);
            held = byp ? d : mix_ref(d);
            chk($sformatf("rnd%0d_val", i), state_out, held);
            chk($sformatf("rnd%0d_lat", i), 128'(lat), byp ? 128'd1 : 128'(NCALC + 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            chk($sformatf("rnd%0d_hold", i), state_out, held);
            consume();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
